// File: rtl/axis_dma_tlp_writer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_dma_tlp_writer                                                      |
// | Packs a 64-bit AXI4-Stream video line into PCIe MWr TLP bursts.          |
// | Optional macro: DMA_STATS_EN (frame / TLP statistics counters).          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axis_dma_tlp_writer #(
    parameter int MAX_PCIE_PAYLOAD_SIZE = 128,
    parameter int FIFO_DEPTH            = 32
) (
    input  logic        axi_clk,
    input  logic        axi_reset_n,
    input  logic        cfg_bus_mast_en,
    input  logic [2:0]  cfg_setmaxpld,
    input  logic [63:0] dma_fstart,
    input  logic [15:0] dma_line_pitch,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [63:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tuser,
    output logic        tlp_req_to_send,
    input  logic        tlp_grant,
    output logic [6:0]  tlp_fmt_type,
    output logic [9:0]  tlp_length_in_dw,
    output logic        tlp_src_rdy_n,
    input  logic        tlp_dst_rdy_n,
    output logic [63:0] tlp_data,
    output logic [63:0] tlp_address,
    output logic [7:0]  tlp_ldwbe_fdwbe,
    output logic [1:0]  tlp_attr,
    output logic [23:0] tlp_transaction_id,
    output logic [12:0] tlp_byte_count,
    output logic [6:0]  tlp_lower_address,
    output logic        irq_eof
`ifdef DMA_STATS_EN
    ,
    output logic [15:0] stat_frame_cnt,
    output logic [31:0] stat_tlp_cnt
`endif
);

    localparam int C_MAX_PLD_WORDS = MAX_PCIE_PAYLOAD_SIZE / 8;
    localparam int C_PTR_W         = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W         = $clog2(FIFO_DEPTH + 1);
    localparam int C_BEAT_W        = $clog2(C_MAX_PLD_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    logic [63:0]          r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_eol;
    logic [FIFO_DEPTH-1:0] r_eof;
    logic [FIFO_DEPTH-1:0] r_sof;
    logic [C_PTR_W-1:0]   r_wr_ptr;
    logic [C_PTR_W-1:0]   r_rd_ptr;
    logic [C_CNT_W-1:0]   r_count;
    logic                 r_tready;
    logic [63:0]          r_pend_fstart;
    logic [15:0]          r_pend_pitch;

    state_t               r_state;
    logic                 r_req;
    logic                 r_src_rdy_n;
    logic [6:0]           r_fmt;
    logic [9:0]           r_len;
    logic [63:0]          r_addr;
    logic [C_BEAT_W-1:0]  r_beats;
    logic [C_BEAT_W-1:0]  r_beat_cnt;
    logic [7:0]           r_tag;
    logic [63:0]          r_burst_addr;
    logic [63:0]          r_line_base;
    logic [15:0]          r_pitch;
    logic                 r_irq;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_last_beat;
    logic                 w_tlp_done;
    logic [C_CNT_W-1:0]   w_count_next;
    logic [C_BEAT_W-1:0]  w_pld_words;
    logic                 w_eol_found;
    logic [C_BEAT_W-1:0]  w_eol_beats;
    logic [C_BEAT_W-1:0]  w_beats;
    logic                 w_launch;
    logic [63:0]          w_head_addr;
    logic                 w_unused;

    assign w_unused     = s_axis_tuser[2];
    assign w_push       = s_axis_tvalid && r_tready;
    assign w_pop        = (r_state == S_DATA) && !tlp_dst_rdy_n;
    assign w_last_beat  = (r_beat_cnt == r_beats - 1'b1);
    assign w_tlp_done   = w_pop && w_last_beat;
    assign w_count_next = r_count + C_CNT_W'(w_push) - C_CNT_W'(w_pop);

    always_ff @(posedge axi_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_axis_tdata;
            r_eol[r_wr_ptr] <= s_axis_tuser[3] | s_axis_tuser[1];
            r_eof[r_wr_ptr] <= s_axis_tuser[1];
            r_sof[r_wr_ptr] <= s_axis_tuser[0];
        end
    end

    // tready is registered from the next-cycle occupancy so it never admits an overflow beat
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_tready      <= 1'b0;
            r_pend_fstart <= '0;
            r_pend_pitch  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == C_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
                if (s_axis_tuser[0]) begin
                    r_pend_fstart <= dma_fstart;
                    r_pend_pitch  <= dma_line_pitch;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count  <= w_count_next;
            r_tready <= (w_count_next < C_CNT_W'(FIFO_DEPTH));
        end
    end

    always_comb begin
        int v_pw;
        v_pw = 16 << cfg_setmaxpld;
        if (v_pw > C_MAX_PLD_WORDS) begin
            v_pw = C_MAX_PLD_WORDS;
        end
        w_pld_words = C_BEAT_W'(v_pw);
    end

    // Burst length: first EOL within the next payload-sized window ends the burst early
    always_comb begin
        int                 v_idx;
        logic [C_PTR_W-1:0] v_ptr;
        w_eol_found = 1'b0;
        w_eol_beats = '0;
        v_idx       = 0;
        v_ptr       = '0;
        for (int i = 0; i < C_MAX_PLD_WORDS; i++) begin
            v_idx = int'(r_rd_ptr) + i;
            if (v_idx >= FIFO_DEPTH) begin
                v_idx = v_idx - FIFO_DEPTH;
            end
            v_ptr = C_PTR_W'(v_idx);
            if (!w_eol_found && (i < int'(w_pld_words)) && (i < int'(r_count)) && r_eol[v_ptr]) begin
                w_eol_found = 1'b1;
                w_eol_beats = C_BEAT_W'(i + 1);
            end
        end
    end

    assign w_beats     = w_eol_found ? w_eol_beats : w_pld_words;
    assign w_launch    = cfg_bus_mast_en && (w_eol_found || (int'(r_count) >= int'(w_pld_words)));
    assign w_head_addr = r_sof[r_rd_ptr] ? r_pend_fstart : r_burst_addr;

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_src_rdy_n  <= 1'b1;
            r_fmt        <= '0;
            r_len        <= '0;
            r_addr       <= '0;
            r_beats      <= '0;
            r_beat_cnt   <= '0;
            r_tag        <= '0;
            r_burst_addr <= '0;
            r_line_base  <= '0;
            r_pitch      <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state    <= S_REQ;
                        r_req      <= 1'b1;
                        r_addr     <= w_head_addr;
                        r_fmt      <= (w_head_addr[63:32] == 32'h0) ? 7'h40 : 7'h60;
                        r_len      <= 10'({w_beats, 1'b0});
                        r_beats    <= w_beats;
                        r_beat_cnt <= '0;
                        if (r_sof[r_rd_ptr]) begin
                            r_line_base <= r_pend_fstart;
                            r_pitch     <= r_pend_pitch;
                        end
                    end
                end
                S_REQ: begin
                    if (tlp_grant) begin
                        r_state     <= S_DATA;
                        r_req       <= 1'b0;
                        r_src_rdy_n <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (!tlp_dst_rdy_n) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_last_beat) begin
                            r_state     <= S_IDLE;
                            r_src_rdy_n <= 1'b1;
                            r_tag       <= r_tag + 1'b1;
                            r_irq       <= r_eof[r_rd_ptr];
                            if (r_eol[r_rd_ptr]) begin
                                r_line_base  <= r_line_base + 64'(r_pitch);
                                r_burst_addr <= r_line_base + 64'(r_pitch);
                            end else begin
                                r_burst_addr <= r_addr + 64'({r_beats, 3'b000});
                            end
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req       <= 1'b0;
                    r_src_rdy_n <= 1'b1;
                end
            endcase
        end
    end

`ifdef DMA_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [31:0] r_tlp_cnt;

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_frame_cnt <= '0;
            r_tlp_cnt   <= '0;
        end else begin
            if (r_irq) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_tlp_done) begin
                r_tlp_cnt <= r_tlp_cnt + 1'b1;
            end
        end
    end

    assign stat_frame_cnt = r_frame_cnt;
    assign stat_tlp_cnt   = r_tlp_cnt;
`else
    logic w_unused_done;
    assign w_unused_done = w_tlp_done;
`endif

    assign s_axis_tready      = r_tready;
    assign tlp_req_to_send    = r_req;
    assign tlp_src_rdy_n      = r_src_rdy_n;
    assign tlp_fmt_type       = r_fmt;
    assign tlp_length_in_dw   = r_len;
    assign tlp_address        = r_addr;
    assign tlp_data           = r_src_rdy_n ? 64'h0 : r_mem[r_rd_ptr];
    assign tlp_ldwbe_fdwbe    = 8'hFF;
    assign tlp_attr           = 2'b00;
    assign tlp_transaction_id = {r_tag, 16'h0000};
    assign tlp_byte_count     = 13'h0;
    assign tlp_lower_address  = 7'h0;
    assign irq_eof            = r_irq;

endmodule
`default_nettype wire
